// File: rtl/key_voice_alloc.sv
// rtl/key_voice_alloc.sv - two-voice polyphony allocator for the eight piano keys
module key_voice_alloc (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  key,
  output logic [1:0]  voice_en,
  output logic [2:0]  voice_key0,
  output logic [2:0]  voice_key1,
  output logic [16:0] voice_div0,
  output logic [16:0] voice_div1,
  output logic [1:0]  voice_load,
  output logic        steal,
  output logic [7:0]  pending
);

  // Half-period terminal counts, C through C2.
  function automatic logic [16:0] div_lookup(input logic [2:0] idx);
    case (idx)
      3'd0:    div_lookup = 17'd95566;
      3'd1:    div_lookup = 17'd85121;
      3'd2:    div_lookup = 17'd75850;
      3'd3:    div_lookup = 17'd71592;
      3'd4:    div_lookup = 17'd63776;
      3'd5:    div_lookup = 17'd56818;
      3'd6:    div_lookup = 17'd50618;
      default: div_lookup = 17'd47774;
    endcase
  endfunction

  logic [7:0]  key_q, key_d;
  logic [7:0]  pending_q, pending_d;
  logic [1:0]  voice_en_q, voice_en_d;
  logic [2:0]  voice_key0_q, voice_key0_d;
  logic [2:0]  voice_key1_q, voice_key1_d;
  logic [16:0] voice_div0_q, voice_div0_d;
  logic [16:0] voice_div1_q, voice_div1_d;
  logic [1:0]  voice_load_q, voice_load_d;
  logic        steal_q, steal_d;
  logic        oldest_q, oldest_d;

  logic [7:0]  press, release_ev, cand;
  logic [2:0]  cand_idx;
  logic        alloc_ok;
  logic        tgt;
  logic        tgt_busy;

  // Edge detection, release handling and single per-cycle allocation.
  always_comb begin
    key_d        = key;
    pending_d    = pending_q;
    voice_en_d   = voice_en_q;
    voice_key0_d = voice_key0_q;
    voice_key1_d = voice_key1_q;
    voice_div0_d = voice_div0_q;
    voice_div1_d = voice_div1_q;
    voice_load_d = 2'b00;
    steal_d      = 1'b0;
    oldest_d     = oldest_q;
    cand_idx     = 3'd0;
    tgt          = 1'b0;
    tgt_busy     = 1'b0;

    press      = key & ~key_q;
    release_ev = key_q & ~key;
    pending_d  = (pending_q & ~release_ev) | press;

    if (voice_en_q[0] && release_ev[voice_key0_q]) voice_en_d[0] = 1'b0;
    if (voice_en_q[1] && release_ev[voice_key1_q]) voice_en_d[1] = 1'b0;

    // Only keys that were latched on an earlier edge and are still held qualify.
    cand     = pending_q & key;
    alloc_ok = (release_ev == 8'h00) && (cand != 8'h00);
    for (int i = 7; i >= 0; i--) begin
      if (cand[i]) cand_idx = 3'(i);
    end

    if (!voice_en_q[0]) begin
      tgt = 1'b0;
    end else if (!voice_en_q[1]) begin
      tgt = 1'b1;
    end else begin
      tgt      = oldest_q;
      tgt_busy = 1'b1;
    end

    if (alloc_ok) begin
      voice_en_d[tgt]   = 1'b1;
      voice_load_d[tgt] = 1'b1;
      steal_d           = tgt_busy;
      pending_d[cand_idx] = 1'b0;
      oldest_d          = ~tgt;
      if (tgt == 1'b0) begin
        voice_key0_d = cand_idx;
        voice_div0_d = div_lookup(cand_idx);
      end else begin
        voice_key1_d = cand_idx;
        voice_div1_d = div_lookup(cand_idx);
      end
    end
  end

  // State register; reset wins over every event in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q        <= 8'h00;
      pending_q    <= 8'h00;
      voice_en_q   <= 2'b00;
      voice_key0_q <= 3'd0;
      voice_key1_q <= 3'd0;
      voice_div0_q <= 17'd0;
      voice_div1_q <= 17'd0;
      voice_load_q <= 2'b00;
      steal_q      <= 1'b0;
      oldest_q     <= 1'b0;
    end else begin
      key_q        <= key_d;
      pending_q    <= pending_d;
      voice_en_q   <= voice_en_d;
      voice_key0_q <= voice_key0_d;
      voice_key1_q <= voice_key1_d;
      voice_div0_q <= voice_div0_d;
      voice_div1_q <= voice_div1_d;
      voice_load_q <= voice_load_d;
      steal_q      <= steal_d;
      oldest_q     <= oldest_d;
    end
  end

  assign voice_en   = voice_en_q;
  assign voice_key0 = voice_key0_q;
  assign voice_key1 = voice_key1_q;
  assign voice_div0 = voice_div0_q;
  assign voice_div1 = voice_div1_q;
  assign voice_load = voice_load_q;
  assign steal      = steal_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_key_voice_alloc.sv
// tb/tb_key_voice_alloc.sv - directed plus randomized check of key_voice_alloc against a behavioural model
module tb_key_voice_alloc;

  logic        clk;
  logic        reset;
  logic [7:0]  key;
  logic [1:0]  voice_en;
  logic [2:0]  voice_key0;
  logic [2:0]  voice_key1;
  logic [16:0] voice_div0;
  logic [16:0] voice_div1;
  logic [1:0]  voice_load;
  logic        steal;
  logic [7:0]  pending;

  int checks = 0;
  int errors = 0;

  key_voice_alloc dut (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .voice_en   (voice_en),
    .voice_key0 (voice_key0),
    .voice_key1 (voice_key1),
    .voice_div0 (voice_div0),
    .voice_div1 (voice_div1),
    .voice_load (voice_load),
    .steal      (steal),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: per-voice owner and assignment time.
  int        tone_tab [8] = '{95566, 85121, 75850, 71592, 63776, 56818, 50618, 47774};
  bit        m_held [8];
  bit        m_pend [8];
  bit        m_on   [2];
  int        m_owner[2];
  int        m_div  [2];
  int        m_when [2];
  bit        m_load [2];
  bit        m_steal;
  int        now;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input logic [7:0] k);
    bit rel_any;
    int pick;
    int v;
    if (r) begin
      for (int i = 0; i < 8; i++) begin m_held[i] = 0; m_pend[i] = 0; end
      for (int n = 0; n < 2; n++) begin
        m_on[n] = 0; m_owner[n] = 0; m_div[n] = 0; m_load[n] = 0; m_when[n] = 0;
      end
      m_steal = 0;
    end else begin
      bit nxt_pend [8];
      rel_any = 0;
      pick = -1;
      m_load[0] = 0; m_load[1] = 0; m_steal = 0;
      for (int i = 0; i < 8; i++) begin
        nxt_pend[i] = m_pend[i];
        if (k[i] && !m_held[i]) nxt_pend[i] = 1;
        if (!k[i] && m_held[i]) begin
          nxt_pend[i] = 0;
          rel_any = 1;
          for (int n = 0; n < 2; n++)
            if (m_on[n] && m_owner[n] == i) m_on[n] = 0;
        end
      end
      if (!rel_any) begin
        for (int i = 7; i >= 0; i--)
          if (m_pend[i] && k[i]) pick = i;
      end
      if (pick >= 0) begin
        if (!m_on[0]) v = 0;
        else if (!m_on[1]) v = 1;
        else begin
          v = (m_when[0] < m_when[1]) ? 0 : 1;
          m_steal = 1;
        end
        m_on[v] = 1;
        m_owner[v] = pick;
        m_div[v] = tone_tab[pick];
        m_when[v] = now;
        m_load[v] = 1;
        nxt_pend[pick] = 0;
      end
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = nxt_pend[i];
        m_held[i] = k[i];
      end
    end
    now++;
  endtask

  task automatic step(input bit r, input logic [7:0] k);
    logic [7:0] exp_pend;
    @(negedge clk);
    reset = r;
    key = k;
    @(posedge clk);
    model_step(r, k);
    #1;
    for (int i = 0; i < 8; i++) exp_pend[i] = m_pend[i];
    check("voice_en",   32'(voice_en),   32'({m_on[1], m_on[0]}));
    check("voice_key0", 32'(voice_key0), 32'(m_owner[0]));
    check("voice_key1", 32'(voice_key1), 32'(m_owner[1]));
    check("voice_div0", 32'(voice_div0), 32'(m_div[0]));
    check("voice_div1", 32'(voice_div1), 32'(m_div[1]));
    check("voice_load", 32'(voice_load), 32'({m_load[1], m_load[0]}));
    check("steal",      32'(steal),      32'(m_steal));
    check("pending",    32'(pending),    32'(exp_pend));
  endtask

  logic [7:0] cur;

  initial begin
    now = 1;
    reset = 1'b1;
    key = 8'h00;
    // Reset with all keys held, then release into allocation of keys 0 and 1.
    step(1, 8'hFF); step(1, 8'hFF);
    step(0, 8'hFF); step(0, 8'hFF); step(0, 8'hFF); step(0, 8'hFF);
    step(1, 8'h00); step(0, 8'h00); step(0, 8'h00);
    // Single press of key 2, then release.
    step(0, 8'h04); step(0, 8'h04); step(0, 8'h04); step(0, 8'h00);
    // Keys 0 and 5 together, then key 7 steals voice 0, then key 0 released.
    step(0, 8'h21); step(0, 8'h21); step(0, 8'h21);
    step(0, 8'hA1); step(0, 8'hA1); step(0, 8'hA0); step(0, 8'hA0);
    // Release 5 and press 3 on one edge.
    step(0, 8'h88); step(0, 8'h88); step(0, 8'h88);
    // Reset mid-note, held keys re-allocate.
    step(1, 8'h88); step(0, 8'h88); step(0, 8'h88); step(0, 8'h88); step(0, 8'h88);
    // Press-and-release before allocation leaves no trace.
    step(0, 8'h8A); step(0, 8'h88); step(0, 8'h88);

    cur = 8'h88;
    for (int c = 0; c < 4000; c++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 30) cur[$urandom_range(0, 7)] ^= 1'b1;
      else if (sel < 36) cur = 8'($urandom);
      if ($urandom_range(0, 249) == 0) step(1, cur);
      else step(0, cur);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
